// File: rtl/c5_shift_arbiter.sv
// Shares one c5_shifter between two valid/ready requesters with registered responses.
// Arbitration is round-robin or fixed priority (req0 wins); accepted shifts are counted.

module c5_shifter (
    input  logic [31:0] i_value,
    input  logic [4:0]  i_amount,
    input  logic [1:0]  i_func,
    output logic [31:0] o_result
);
    // func: 00 left unsigned, 01 left signed, 10 right unsigned, 11 right signed
    always_comb begin
        o_result = i_value;
        case (i_func)
            2'b00, 2'b01: o_result = i_value << i_amount;
            2'b10:        o_result = i_value >> i_amount;
            2'b11:        o_result = $signed(i_value) >>> i_amount;
            default:      o_result = i_value;
        endcase
    end
endmodule

module c5_shift_arbiter #(
    parameter bit PRIORITY_RR = 1'b1,
    parameter int CNT_W       = 16
) (
    input  logic             I_clk,
    input  logic             I_reset,
    input  logic             I_req0_valid,
    output logic             O_req0_ready,
    input  logic [31:0]      I_req0_value,
    input  logic [4:0]       I_req0_amount,
    input  logic [1:0]       I_req0_func,
    input  logic             I_req1_valid,
    output logic             O_req1_ready,
    input  logic [31:0]      I_req1_value,
    input  logic [4:0]       I_req1_amount,
    input  logic [1:0]       I_req1_func,
    output logic             O_rsp0_valid,
    input  logic             I_rsp0_ready,
    output logic [31:0]      O_rsp0_result,
    output logic             O_rsp1_valid,
    input  logic             I_rsp1_ready,
    output logic [31:0]      O_rsp1_result,
    output logic [CNT_W-1:0] O_ops_count
);
    logic             r_rsp0_valid;
    logic             r_rsp1_valid;
    logic [31:0]      r_rsp0_result;
    logic [31:0]      r_rsp1_result;
    logic [CNT_W-1:0] r_ops_count;
    logic             r_pref1;

    logic        w_free0;
    logic        w_free1;
    logic        w_elig0;
    logic        w_elig1;
    logic        w_grant0;
    logic        w_grant1;
    logic [31:0] w_sh_value;
    logic [4:0]  w_sh_amount;
    logic [1:0]  w_sh_func;
    logic [31:0] w_sh_result;

    // A held response may drain and be refilled in the same cycle.
    assign w_free0 = !r_rsp0_valid || I_rsp0_ready;
    assign w_free1 = !r_rsp1_valid || I_rsp1_ready;
    assign w_elig0 = I_req0_valid && w_free0 && !I_reset;
    assign w_elig1 = I_req1_valid && w_free1 && !I_reset;

    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if (w_elig0 && w_elig1) begin
            if (PRIORITY_RR && r_pref1) w_grant1 = 1'b1;
            else                        w_grant0 = 1'b1;
        end else begin
            w_grant0 = w_elig0;
            w_grant1 = w_elig1;
        end
    end

    assign O_req0_ready = w_grant0;
    assign O_req1_ready = w_grant1;

    always_comb begin
        w_sh_value  = I_req0_value;
        w_sh_amount = I_req0_amount;
        w_sh_func   = I_req0_func;
        if (w_grant1) begin
            w_sh_value  = I_req1_value;
            w_sh_amount = I_req1_amount;
            w_sh_func   = I_req1_func;
        end
    end

    c5_shifter u_shifter (
        .i_value  (w_sh_value),
        .i_amount (w_sh_amount),
        .i_func   (w_sh_func),
        .o_result (w_sh_result)
    );

    always_ff @(posedge I_clk) begin
        if (I_reset) begin
            r_rsp0_valid  <= 1'b0;
            r_rsp0_result <= 32'd0;
        end else if (w_grant0) begin
            r_rsp0_valid  <= 1'b1;
            r_rsp0_result <= w_sh_result;
        end else if (I_rsp0_ready) begin
            r_rsp0_valid  <= 1'b0;
        end
    end

    always_ff @(posedge I_clk) begin
        if (I_reset) begin
            r_rsp1_valid  <= 1'b0;
            r_rsp1_result <= 32'd0;
        end else if (w_grant1) begin
            r_rsp1_valid  <= 1'b1;
            r_rsp1_result <= w_sh_result;
        end else if (I_rsp1_ready) begin
            r_rsp1_valid  <= 1'b0;
        end
    end

    // Pointer moves only on a grant: the loser becomes preferred.
    always_ff @(posedge I_clk) begin
        if (I_reset) begin
            r_pref1     <= 1'b0;
            r_ops_count <= '0;
        end else if (w_grant0 || w_grant1) begin
            r_pref1     <= w_grant0;
            r_ops_count <= r_ops_count + CNT_W'(1);
        end
    end

    assign O_rsp0_valid  = r_rsp0_valid;
    assign O_rsp1_valid  = r_rsp1_valid;
    assign O_rsp0_result = r_rsp0_result;
    assign O_rsp1_result = r_rsp1_result;
    assign O_ops_count   = r_ops_count;
endmodule

// File: tb/tb_c5_shift_arbiter.sv
// Directed bench for c5_shift_arbiter: a round-robin instance and a fixed-priority instance.

module tb_c5_shift_arbiter;
    localparam logic [1:0] SLU = 2'b00;
    localparam logic [1:0] SRU = 2'b10;
    localparam logic [1:0] SRS = 2'b11;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // round-robin instance
    logic        a_reset = 1'b0;
    logic        a_v0 = 0, a_v1 = 0, a_r0, a_r1;
    logic [31:0] a_val0 = 0, a_val1 = 0;
    logic [4:0]  a_amt0 = 0, a_amt1 = 0;
    logic [1:0]  a_fn0 = 0, a_fn1 = 0;
    logic        a_rv0, a_rv1, a_rr0 = 0, a_rr1 = 0;
    logic [31:0] a_res0, a_res1;
    logic [15:0] a_cnt;

    // fixed-priority instance
    logic        f_reset = 1'b0;
    logic        f_v0 = 0, f_v1 = 0, f_r0, f_r1;
    logic [31:0] f_val0 = 0, f_val1 = 0;
    logic [4:0]  f_amt0 = 0, f_amt1 = 0;
    logic [1:0]  f_fn0 = 0, f_fn1 = 0;
    logic        f_rv0, f_rv1, f_rr0 = 0, f_rr1 = 0;
    logic [31:0] f_res0, f_res1;
    logic [15:0] f_cnt;

    c5_shift_arbiter #(.PRIORITY_RR(1'b1), .CNT_W(16)) dut_rr (
        .I_clk(clk), .I_reset(a_reset),
        .I_req0_valid(a_v0), .O_req0_ready(a_r0), .I_req0_value(a_val0),
        .I_req0_amount(a_amt0), .I_req0_func(a_fn0),
        .I_req1_valid(a_v1), .O_req1_ready(a_r1), .I_req1_value(a_val1),
        .I_req1_amount(a_amt1), .I_req1_func(a_fn1),
        .O_rsp0_valid(a_rv0), .I_rsp0_ready(a_rr0), .O_rsp0_result(a_res0),
        .O_rsp1_valid(a_rv1), .I_rsp1_ready(a_rr1), .O_rsp1_result(a_res1),
        .O_ops_count(a_cnt)
    );

    c5_shift_arbiter #(.PRIORITY_RR(1'b0), .CNT_W(16)) dut_fx (
        .I_clk(clk), .I_reset(f_reset),
        .I_req0_valid(f_v0), .O_req0_ready(f_r0), .I_req0_value(f_val0),
        .I_req0_amount(f_amt0), .I_req0_func(f_fn0),
        .I_req1_valid(f_v1), .O_req1_ready(f_r1), .I_req1_value(f_val1),
        .I_req1_amount(f_amt1), .I_req1_func(f_fn1),
        .O_rsp0_valid(f_rv0), .I_rsp0_ready(f_rr0), .O_rsp0_result(f_res0),
        .O_rsp1_valid(f_rv1), .I_rsp1_ready(f_rr1), .O_rsp1_result(f_res1),
        .O_ops_count(f_cnt)
    );

    // Inputs change 1 time unit after the rising edge; combinational checks follow a further #1.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_a();
        a_reset = 1'b1; a_v0 = 0; a_v1 = 0; a_rr0 = 0; a_rr1 = 0;
        step();
        a_reset = 1'b0;
    endtask

    task automatic test_reset();
        a_reset = 1'b1; a_v0 = 1; a_v1 = 1; a_rr0 = 1; a_rr1 = 1;
        #1;
        checks++;
        if ({a_r0, a_r1} !== 2'b00) begin
            errors++; $display("FAIL reset_ready: got %b expected 00", {a_r0, a_r1});
        end
        step();
        a_reset = 1'b0; a_v0 = 0; a_v1 = 0;
        checks++;
        if ({a_rv0, a_rv1, a_res0, a_res1, a_cnt} !== {2'b00, 64'd0, 16'd0}) begin
            errors++; $display("FAIL reset_state: got v=%b%b r0=%h r1=%h cnt=%0d expected all zero",
                               a_rv0, a_rv1, a_res0, a_res1, a_cnt);
        end
    endtask

    task automatic test_single();
        reset_a();
        a_v0 = 1; a_val0 = 32'h10; a_amt0 = 4; a_fn0 = SLU; a_rr0 = 1;
        #1;
        checks++;
        if ({a_r0, a_r1} !== 2'b10) begin
            errors++; $display("FAIL single_ready: got %b expected 10", {a_r0, a_r1});
        end
        step();
        a_v0 = 0;
        checks++;
        if (a_rv0 !== 1'b1 || a_res0 !== 32'h100 || a_cnt !== 16'd1) begin
            errors++; $display("FAIL single_rsp: got v=%b res=%h cnt=%0d expected 1 00000100 1", a_rv0, a_res0, a_cnt);
        end
        step();
        checks++;
        if (a_rv0 !== 1'b0 || a_res0 !== 32'h100) begin
            errors++; $display("FAIL single_drain: got v=%b res=%h expected 0 00000100", a_rv0, a_res0);
        end
    endtask

    task automatic test_round_robin();
        reset_a();
        a_v0 = 1; a_val0 = 32'h10; a_amt0 = 4; a_fn0 = SRU; a_rr0 = 1;
        a_v1 = 1; a_val1 = 32'h8000_0000; a_amt1 = 4; a_fn1 = SRS; a_rr1 = 1;
        #1;
        checks++;
        if ({a_r0, a_r1} !== 2'b10) begin
            errors++; $display("FAIL rr_first: got %b expected 10", {a_r0, a_r1});
        end
        step();
        checks++;
        if (a_rv0 !== 1'b1 || a_res0 !== 32'h1 || a_r1 !== 1'b1 || a_r0 !== 1'b0) begin
            errors++; $display("FAIL rr_second: got v0=%b res0=%h rdy=%b%b expected 1 00000001 01", a_rv0, a_res0, a_r0, a_r1);
        end
        step();
        checks++;
        if (a_rv1 !== 1'b1 || a_res1 !== 32'hF800_0000) begin
            errors++; $display("FAIL rr_rsp1: got v=%b res=%h expected 1 f8000000", a_rv1, a_res1);
        end
        for (int i = 0; i < 6; i++) begin
            logic exp0;
            exp0 = (i % 2 == 0);
            checks++;
            if (a_r0 !== exp0 || a_r1 !== !exp0) begin
                errors++; $display("FAIL rr_alternate[%0d]: got %b%b expected %b%b", i, a_r0, a_r1, exp0, !exp0);
            end
            step();
        end
        checks++;
        if (a_cnt !== 16'd8) begin
            errors++; $display("FAIL rr_count: got %0d expected 8", a_cnt);
        end
        a_v0 = 0; a_v1 = 0;
    endtask

    task automatic test_backpressure();
        reset_a();
        a_v0 = 1; a_val0 = 32'h3; a_amt0 = 2; a_fn0 = SLU; a_rr0 = 0;
        a_v1 = 1; a_val1 = 32'h0; a_amt1 = 1; a_fn1 = SLU; a_rr1 = 1;
        step();
        a_val0 = 32'hFF;
        for (int i = 0; i < 4; i++) begin
            a_val1 = 32'(i + 1);
            #1;
            checks++;
            if ({a_r0, a_r1} !== 2'b01) begin
                errors++; $display("FAIL bp_ready[%0d]: got %b expected 01", i, {a_r0, a_r1});
            end
            step();
            checks++;
            if (a_rv0 !== 1'b1 || a_res0 !== 32'hC || a_rv1 !== 1'b1 || a_res1 !== 32'((i + 1) * 2)) begin
                errors++; $display("FAIL bp_hold[%0d]: got v0=%b res0=%h v1=%b res1=%h expected 1 0000000c 1 %h",
                                   i, a_rv0, a_res0, a_rv1, a_res1, 32'((i + 1) * 2));
            end
        end
        a_rr0 = 1;
        #1;
        checks++;
        if ({a_r0, a_r1} !== 2'b10) begin
            errors++; $display("FAIL bp_release: got %b expected 10", {a_r0, a_r1});
        end
        step();
        a_v0 = 0; a_v1 = 0;
        checks++;
        if (a_res0 !== 32'h3FC) begin
            errors++; $display("FAIL bp_release_rsp: got %h expected 000003fc", a_res0);
        end
    endtask

    task automatic test_stream();
        reset_a();
        a_rr0 = 1; a_v0 = 1; a_fn0 = SLU;
        for (int i = 0; i < 5; i++) begin
            a_val0 = 32'(i + 1); a_amt0 = 5'(i);
            #1;
            checks++;
            if (a_r0 !== 1'b1) begin
                errors++; $display("FAIL stream_ready[%0d]: got %b expected 1", i, a_r0);
            end
            step();
            checks++;
            if (a_rv0 !== 1'b1 || a_res0 !== (32'(i + 1) << i)) begin
                errors++; $display("FAIL stream_rsp[%0d]: got v=%b res=%h expected 1 %h", i, a_rv0, a_res0, 32'(i + 1) << i);
            end
        end
        a_v0 = 0;
        checks++;
        if (a_cnt !== 16'd5) begin
            errors++; $display("FAIL stream_count: got %0d expected 5", a_cnt);
        end
    endtask

    task automatic test_reset_mid();
        reset_a();
        a_val0 = 32'h1; a_amt0 = 1; a_fn0 = SLU;
        a_val1 = 32'h1; a_amt1 = 2; a_fn1 = SLU;
        a_v1 = 1;
        step();
        a_v0 = 1;
        step();
        checks++;
        if ({a_rv0, a_rv1} !== 2'b11) begin
            errors++; $display("FAIL mid_setup: got %b expected 11", {a_rv0, a_rv1});
        end
        a_reset = 1; a_rr0 = 1; a_rr1 = 1;
        #1;
        checks++;
        if ({a_r0, a_r1} !== 2'b00) begin
            errors++; $display("FAIL mid_ready_in_reset: got %b expected 00", {a_r0, a_r1});
        end
        step();
        a_reset = 0;
        checks++;
        if ({a_rv0, a_rv1, a_res0, a_res1, a_cnt} !== {2'b00, 64'd0, 16'd0}) begin
            errors++; $display("FAIL mid_cleared: got v=%b%b r0=%h r1=%h cnt=%0d expected all zero",
                               a_rv0, a_rv1, a_res0, a_res1, a_cnt);
        end
        #1;
        checks++;
        if ({a_r0, a_r1} !== 2'b10) begin
            errors++; $display("FAIL mid_pref0: got %b expected 10", {a_r0, a_r1});
        end
        a_v0 = 0; a_v1 = 0;
    endtask

    task automatic test_fixed_priority();
        f_reset = 1; step(); f_reset = 0;
        f_v0 = 1; f_val0 = 32'h5; f_amt0 = 1; f_fn0 = SLU; f_rr0 = 1;
        f_v1 = 1; f_val1 = 32'h40; f_amt1 = 3; f_fn1 = SRU; f_rr1 = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if ({f_r0, f_r1} !== 2'b10) begin
                errors++; $display("FAIL fx_req0_wins[%0d]: got %b expected 10", i, {f_r0, f_r1});
            end
            step();
        end
        f_v0 = 0;
        #1;
        checks++;
        if ({f_r0, f_r1} !== 2'b01) begin
            errors++; $display("FAIL fx_req1_after_drop: got %b expected 01", {f_r0, f_r1});
        end
        step();
        f_v1 = 0;
        checks++;
        if (f_rv1 !== 1'b1 || f_res1 !== 32'h8 || f_cnt !== 16'd5) begin
            errors++; $display("FAIL fx_rsp1: got v=%b res=%h cnt=%0d expected 1 00000008 5", f_rv1, f_res1, f_cnt);
        end
    endtask

    task automatic test_count_wrap();
        f_reset = 1; step(); f_reset = 0;
        f_v0 = 1; f_rr0 = 1;
        repeat (65535) step();
        checks++;
        if (f_cnt !== 16'hFFFF) begin
            errors++; $display("FAIL wrap_allones: got %h expected ffff", f_cnt);
        end
        step();
        checks++;
        if (f_cnt !== 16'h0000) begin
            errors++; $display("FAIL wrap_zero: got %h expected 0000", f_cnt);
        end
        step();
        f_v0 = 0;
        checks++;
        if (f_cnt !== 16'h0001) begin
            errors++; $display("FAIL wrap_one: got %h expected 0001", f_cnt);
        end
    endtask

    initial begin
        step();
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_stream();
        test_reset_mid();
        test_fixed_priority();
        test_count_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
